// File: rtl/mux4_arbiter_pkg.sv
// Shared types and sizes for the four-requester mux arbiter.
package mux_arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {IDLE, LOCKED} arb_state_t;
    typedef logic [SEL_W-1:0] sel_t;

    function automatic sel_t next_sel(sel_t s);
        return s + sel_t'(1);
    endfunction
endpackage

// File: rtl/mux4_arbiter_if.sv
// Requester/consumer handshake bundle for mux4_arbiter.
interface mux_arb_if #(parameter int WIDTH = 32);
    import mux_arb_pkg::*;

    logic [N_REQ-1:0] req_valid;
    logic [WIDTH-1:0] req_data [N_REQ-1:0];
    logic [N_REQ-1:0] req_last;
    logic [N_REQ-1:0] req_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    sel_t             out_src;
    logic             out_last;
    logic             out_ready;
    logic             busy;

    modport master (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_src,
        output out_last, busy
    );

    modport slave (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_src,
        input  out_last, busy
    );
endinterface

// File: rtl/mux4_32.sv
// Plain 32-bit 4:1 mux, select s picks d0..d3.
module mux4_32 (
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    input  logic [1:0]  s,
    output logic [31:0] y
);
    always_comb begin
        y = d0;
        unique case (s)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
        endcase
    end
endmodule

// File: rtl/mux4_arbiter_rr_pick4.sv
// Rotating-priority pick: first set req bit at ptr, ptr+1, ... mod 4.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output sel_t             gnt_idx,
    output logic             any
);
    always_comb begin
        gnt_idx = ptr;
        any     = |req;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ptr + sel_t'(k)]) gnt_idx = ptr + sel_t'(k);
        end
    end
endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter over mux4_32 with packet lock and a
// registered valid/ready output stage.
module mux4_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    mux_arb_if.master bus
);
    arb_state_t       state, state_n;
    sel_t             ptr, ptr_n;
    sel_t             owner, owner_n;
    sel_t             pick_idx, win;
    logic             any, load_en, accept, win_last;
    logic [N_REQ-1:0] ready;
    logic [31:0]      mux_y;

    logic             ov_q;
    logic [WIDTH-1:0] od_q;
    sel_t             os_q;
    logic             ol_q;

    rr_pick4 u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .any     (any)
    );

    mux4_32 u_mux (
        .d0 (bus.req_data[0]),
        .d1 (bus.req_data[1]),
        .d2 (bus.req_data[2]),
        .d3 (bus.req_data[3]),
        .s  (win),
        .y  (mux_y)
    );

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        owner_n  = owner;
        ready    = '0;
        load_en  = !ov_q || bus.out_ready;
        win      = (state == LOCKED) ? owner : pick_idx;
        if (rst && load_en) begin
            unique case (state)
                IDLE:   if (any) ready[pick_idx] = 1'b1;
                LOCKED: ready[owner] = 1'b1;
            endcase
        end
        accept   = |(bus.req_valid & ready);
        win_last = bus.req_last[win];
        if (accept) begin
            if (win_last) begin
                state_n = IDLE;
                ptr_n   = next_sel(win);
            end else begin
                state_n = LOCKED;
                owner_n = win;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            ov_q  <= 1'b0;
            od_q  <= '0;
            os_q  <= '0;
            ol_q  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            if (accept) begin
                ov_q <= 1'b1;
                od_q <= mux_y;
                os_q <= win;
                ol_q <= win_last;
            end else if (bus.out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_src   = os_q;
    assign bus.out_last  = ol_q;
    assign bus.busy      = (state == LOCKED);
endmodule

// File: tb/tb_mux4_arbiter.sv
// Vector table plus beat scoreboard for mux4_arbiter.
module tb_mux4_arbiter;
    import mux_arb_pkg::*;

    typedef struct {
        logic             rst;
        logic [3:0]       valid;
        logic [3:0]       last;
        logic             ordy;
        logic [3:0][31:0] d;
        logic [3:0]       exp_ready;
        logic             exp_ov;
        logic [1:0]       exp_src;
        logic [31:0]      exp_data;
        logic             exp_last;
        logic             exp_busy;
    } vec_t;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    checks = 0;
    int    failures = 0;
    beat_t sb[$];
    vec_t  tv[$];

    always #5 clk = ~clk;

    mux_arb_if #(.WIDTH(32)) bus();

    mux4_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic r, input logic [3:0] valid, input logic [3:0] last,
        input logic ordy, input logic [3:0][31:0] d,
        input logic [3:0] er, input logic eov, input logic [1:0] esrc,
        input logic [31:0] edata, input logic elast, input logic ebusy);
        vec_t v;
        v.rst = r;       v.valid = valid; v.last = last;
        v.ordy = ordy;   v.d = d;         v.exp_ready = er;
        v.exp_ov = eov;  v.exp_src = esrc; v.exp_data = edata;
        v.exp_last = elast; v.exp_busy = ebusy;
        return v;
    endfunction

    task automatic run(input vec_t v, input int n);
        beat_t b;
        @(negedge clk);
        rst = v.rst;
        bus.req_valid = v.valid;
        bus.req_last  = v.last;
        bus.out_ready = v.ordy;
        for (int i = 0; i < 4; i++) bus.req_data[i] = v.d[i];
        #1;
        check($sformatf("v%0d req_ready", n),
              32'(bus.req_ready), 32'(v.exp_ready));
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check($sformatf("v%0d sb_pop_empty", n), 32'd1, 32'd0);
            end else begin
                b = sb.pop_front();
                check($sformatf("v%0d sb_src", n),
                      32'(bus.out_src), 32'(b.src));
                check($sformatf("v%0d sb_data", n), bus.out_data, b.data);
                check($sformatf("v%0d sb_last", n),
                      32'(bus.out_last), 32'(b.last));
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                b.src  = 2'(i);
                b.data = bus.req_data[i];
                b.last = bus.req_last[i];
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_valid", n),
              32'(bus.out_valid), 32'(v.exp_ov));
        check($sformatf("v%0d busy", n), 32'(bus.busy), 32'(v.exp_busy));
        if (v.exp_ov || !v.rst) begin
            check($sformatf("v%0d out_src", n),
                  32'(bus.out_src), 32'(v.exp_src));
            check($sformatf("v%0d out_data", n), bus.out_data, v.exp_data);
            check($sformatf("v%0d out_last", n),
                  32'(bus.out_last), 32'(v.exp_last));
        end
        if (!v.rst) sb.delete();
    endtask

    initial begin
        logic [3:0][31:0] da, dl, d2, d3, db, de, de2, df, dr;
        int n;
        da  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        dl  = {32'h0, 32'h11, 32'hB1, 32'hB0};
        d2  = {32'h0, 32'h22, 32'hB1, 32'hB0};
        d3  = {32'h0, 32'h33, 32'hB1, 32'hB0};
        db  = {32'h0, 32'hC2, 32'hDEADBEEF, 32'hC0};
        de  = {32'hE3, 32'h0, 32'h0, 32'h0};
        de2 = {32'hE4, 32'h0, 32'h0, 32'h0};
        df  = {32'hF3, 32'h0, 32'h0, 32'hF0};
        dr  = {32'h0, 32'h0, 32'h101, 32'h200};

        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus.req_data[i] = '0;

        // reset with everyone requesting
        tv.push_back(mk(0, 4'hF, 4'hF, 1, da, 4'h0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'hF, 4'hF, 1, da, 4'h0, 0, 0, 0, 0, 0));
        // single-beat round robin 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            tv.push_back(mk(1, 4'hF, 4'hF, 1, da, 4'(1 << (k % 4)), 1,
                            2'(k % 4), 32'hA0 + 32'(k % 4), 1, 0));
        end
        // lock: r1 moves ptr to 2, then r2 sends 3 beats
        tv.push_back(mk(1, 4'b0010, 4'b0010, 1, dl, 4'b0010, 1, 1, 32'hB1, 1, 0));
        tv.push_back(mk(1, 4'b0111, 4'b0011, 1, dl, 4'b0100, 1, 2, 32'h11, 0, 1));
        tv.push_back(mk(1, 4'b0111, 4'b0011, 1, d2, 4'b0100, 1, 2, 32'h22, 0, 1));
        tv.push_back(mk(1, 4'b0111, 4'b0111, 1, d3, 4'b0100, 1, 2, 32'h33, 1, 0));
        tv.push_back(mk(1, 4'b0011, 4'b0011, 1, d3, 4'b0001, 1, 0, 32'hB0, 1, 0));
        // backpressure on a held 0xDEADBEEF
        tv.push_back(mk(1, 4'b0010, 4'b0010, 1, db, 4'b0010, 1, 1, 32'hDEADBEEF, 1, 0));
        for (int k = 0; k < 4; k++) begin
            tv.push_back(mk(1, 4'b0101, 4'b0101, 0, db, 4'b0000, 1, 1,
                            32'hDEADBEEF, 1, 0));
        end
        tv.push_back(mk(1, 4'b0101, 4'b0101, 1, db, 4'b0100, 1, 2, 32'hC2, 1, 0));
        // only r3, wrap ptr to 0, then drain
        tv.push_back(mk(1, 4'b1000, 4'b1000, 1, de, 4'b1000, 1, 3, 32'hE3, 1, 0));
        tv.push_back(mk(1, 4'b1000, 4'b1000, 1, de2, 4'b1000, 1, 3, 32'hE4, 1, 0));
        tv.push_back(mk(1, 4'b0000, 4'b0000, 1, de2, 4'b0000, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 4'b1001, 4'b1001, 1, df, 4'b0001, 1, 0, 32'hF0, 1, 0));
        // reset in the middle of a packet from r1
        tv.push_back(mk(1, 4'b0010, 4'b0000, 1, dr, 4'b0010, 1, 1, 32'h101, 0, 1));
        tv.push_back(mk(0, 4'b0010, 4'b0000, 1, dr, 4'b0000, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 4'b0011, 4'b0001, 1, dr, 4'b0001, 1, 0, 32'h200, 1, 0));
        tv.push_back(mk(1, 4'b0000, 4'b0000, 1, dr, 4'b0000, 0, 0, 0, 0, 0));

        n = 0;
        foreach (tv[i]) begin
            run(tv[i], n);
            n++;
        end

        // two-beat packets, all requesting: contiguous grants from ptr=1
        for (int p = 0; p < 4; p++) begin
            int s;
            s = (1 + p) % 4;
            run(mk(1, 4'hF, 4'h0, 1, da, 4'(1 << s), 1, 2'(s),
                   32'hA0 + 32'(s), 0, 1), n);
            n++;
            run(mk(1, 4'hF, 4'hF, 1, da, 4'(1 << s), 1, 2'(s),
                   32'hA0 + 32'(s), 1, 0), n);
            n++;
        end
        run(mk(1, 4'h0, 4'h0, 1, da, 4'h0, 0, 0, 0, 0, 0), n);

        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
